// File: rtl/dual_input_debouncer_pkg.sv
// rtl/dual_input_debouncer_pkg.sv - shared states and defaults for the dual debouncer
package dual_input_debouncer_pkg;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 4;

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'd0,
        WAIT_HIGH   = 2'd1,
        STABLE_HIGH = 2'd2,
        WAIT_LOW    = 2'd3
    } db_state_e;

    // The debounced level is high while settled high or while a fall is still unconfirmed.
    function automatic logic state_is_high(input db_state_e st);
        return (st == STABLE_HIGH) || (st == WAIT_LOW);
    endfunction

endpackage

// File: rtl/dual_input_debouncer_if.sv
// rtl/dual_input_debouncer_if.sv - raw inputs and debounced outputs for both channels
interface dual_input_debouncer_if;

    logic i_raw_a;
    logic i_raw_b;
    logic o_a;
    logic o_b;
    logic o_a_rise;
    logic o_b_rise;

    modport master (
        output i_raw_a,
        output i_raw_b,
        input  o_a,
        input  o_b,
        input  o_a_rise,
        input  o_b_rise
    );

    modport slave (
        input  i_raw_a,
        input  i_raw_b,
        output o_a,
        output o_b,
        output o_a_rise,
        output o_b_rise
    );

endinterface

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one channel: 2-flop synchronizer, debounce FSM, rise pulse
module debounce_channel
    import dual_input_debouncer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_raw,
    output logic o_level,
    output logic o_rise
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_q1;
    logic          sync_q2;
    db_state_e     state_q;
    db_state_e     state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          level_q;
    logic          level_d;
    logic          rise_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= i_raw;
            sync_q2 <= sync_q1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= STABLE_LOW;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= level_d & ~level_q;
        end
    end

    // The count restarts at 1 on the first differing sample, so the terminal
    // check at CNT_LAST means DEBOUNCE_CYCLES consecutive samples; it never wraps.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            STABLE_LOW: begin
                if (sync_q2) begin
                    state_d = WAIT_HIGH;
                    cnt_d   = CW'(1);
                end else begin
                    cnt_d   = '0;
                end
            end
            WAIT_HIGH: begin
                if (!sync_q2) begin
                    state_d = STABLE_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_HIGH;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            STABLE_HIGH: begin
                if (!sync_q2) begin
                    state_d = WAIT_LOW;
                    cnt_d   = CW'(1);
                end else begin
                    cnt_d   = '0;
                end
            end
            WAIT_LOW: begin
                if (sync_q2) begin
                    state_d = STABLE_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_LOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = STABLE_LOW;
                cnt_d   = '0;
            end
        endcase
        level_d = state_is_high(state_d);
    end

    assign o_level = level_q;
    assign o_rise  = rise_q;

endmodule

// File: rtl/dual_input_debouncer.sv
// rtl/dual_input_debouncer.sv - two independent debounced channels A and B
module dual_input_debouncer
    import dual_input_debouncer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    dual_input_debouncer_if.slave bus
);

    debounce_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_chan_a (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_raw   (bus.i_raw_a),
        .o_level (bus.o_a),
        .o_rise  (bus.o_a_rise)
    );

    debounce_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_chan_b (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_raw   (bus.i_raw_b),
        .o_level (bus.o_b),
        .o_rise  (bus.o_b_rise)
    );

endmodule

// File: tb/tb_dual_input_debouncer.sv
// tb/tb_dual_input_debouncer.sv - directed bench for dual_input_debouncer at N=4 and N=2
module tb_dual_input_debouncer;

    logic clk = 1'b0;
    logic rst_n;
    int   tests_run = 0;
    int   tests_failed = 0;
    int   rises;
    int   highs;

    dual_input_debouncer_if bus4 ();
    dual_input_debouncer_if bus2 ();

    dual_input_debouncer #(.DEBOUNCE_CYCLES(4)) u_dut4 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus4)
    );

    dual_input_debouncer #(.DEBOUNCE_CYCLES(2)) u_dut2 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    initial begin
        rst_n        = 1'b0;
        bus4.i_raw_a = 1'b0;
        bus4.i_raw_b = 1'b0;
        bus2.i_raw_a = 1'b0;
        bus2.i_raw_b = 1'b0;
        repeat (3) tick();
        check("rst_a",      32'(bus4.o_a),      0);
        check("rst_b",      32'(bus4.o_b),      0);
        check("rst_a_rise", 32'(bus4.o_a_rise), 0);
        check("rst_b_rise", 32'(bus4.o_b_rise), 0);
        check("rst_n2_a",   32'(bus2.o_a),      0);
        at_neg();
        rst_n = 1'b1;
        tick();
        tick();

        // A rises and is held: output and pulse at edge 6
        at_neg();
        bus4.i_raw_a = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            tick();
            if (e == 5) check("rise_a_e5", 32'(bus4.o_a), 0);
            if (e == 6) begin
                check("rise_a_e6",      32'(bus4.o_a),      1);
                check("rise_a_pulse6",  32'(bus4.o_a_rise), 1);
                check("rise_b_quiet6",  32'(bus4.o_b),      0);
            end
            if (e == 7) begin
                check("rise_a_e7",      32'(bus4.o_a),      1);
                check("rise_a_pulse7",  32'(bus4.o_a_rise), 0);
            end
        end

        // A falls and is held: output drops at edge 6, no pulse
        at_neg();
        bus4.i_raw_a = 1'b0;
        rises = 0;
        for (int e = 1; e <= 7; e++) begin
            tick();
            rises += int'(bus4.o_a_rise);
            if (e == 5) check("fall_a_e5", 32'(bus4.o_a), 1);
            if (e == 6) check("fall_a_e6", 32'(bus4.o_a), 0);
        end
        check("fall_no_pulse", 32'(rises), 0);

        // Three-sample glitch is filtered
        rises = 0;
        highs = 0;
        at_neg();
        bus4.i_raw_a = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            tick();
            rises += int'(bus4.o_a_rise);
            highs += int'(bus4.o_a);
        end
        at_neg();
        bus4.i_raw_a = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            tick();
            rises += int'(bus4.o_a_rise);
            highs += int'(bus4.o_a);
        end
        check("glitch_level", 32'(highs), 0);
        check("glitch_pulse", 32'(rises), 0);

        // A and B rise together
        at_neg();
        bus4.i_raw_a = 1'b1;
        bus4.i_raw_b = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            tick();
            if (e == 5) begin
                check("both_a_e5", 32'(bus4.o_a), 0);
                check("both_b_e5", 32'(bus4.o_b), 0);
            end
            if (e == 6) begin
                check("both_a_e6",     32'(bus4.o_a),      1);
                check("both_b_e6",     32'(bus4.o_b),      1);
                check("both_arise_e6", 32'(bus4.o_a_rise), 1);
                check("both_brise_e6", 32'(bus4.o_b_rise), 1);
            end
            if (e == 7) begin
                check("both_arise_e7", 32'(bus4.o_a_rise), 0);
                check("both_brise_e7", 32'(bus4.o_b_rise), 0);
            end
        end

        // Reset mid-debounce: A partially counted, B settled high
        at_neg();
        bus4.i_raw_a = 1'b0;
        repeat (8) tick();
        check("pre_rst_a", 32'(bus4.o_a), 0);
        check("pre_rst_b", 32'(bus4.o_b), 1);
        at_neg();
        bus4.i_raw_a = 1'b1;
        repeat (3) tick();
        at_neg();
        rst_n = 1'b0;
        #1;
        check("async_rst_a", 32'(bus4.o_a), 0);
        check("async_rst_b", 32'(bus4.o_b), 0);
        tick();
        at_neg();
        rst_n = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            tick();
            if (e == 5) begin
                check("post_rst_a_e5", 32'(bus4.o_a), 0);
                check("post_rst_b_e5", 32'(bus4.o_b), 0);
            end
            if (e == 6) begin
                check("post_rst_a_e6",    32'(bus4.o_a),      1);
                check("post_rst_b_e6",    32'(bus4.o_b),      1);
                check("post_rst_arise6",  32'(bus4.o_a_rise), 1);
            end
        end

        // N=2: bouncing then held high gives exactly one pulse, at edge 4
        rises = 0;
        for (int i = 0; i < 10; i++) begin
            at_neg();
            bus2.i_raw_a = (i % 2 == 0) ? 1'b1 : 1'b0;
            tick();
            rises += int'(bus2.o_a_rise);
        end
        at_neg();
        bus2.i_raw_a = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            tick();
            rises += int'(bus2.o_a_rise);
            if (e == 3) check("n2_a_e3", 32'(bus2.o_a), 0);
            if (e == 4) begin
                check("n2_a_e4",     32'(bus2.o_a),      1);
                check("n2_arise_e4", 32'(bus2.o_a_rise), 1);
            end
            if (e == 5) check("n2_arise_e5", 32'(bus2.o_a_rise), 0);
        end
        check("n2_single_pulse", 32'(rises), 1);
        check("n2_b_quiet",      32'(bus2.o_b), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/dual_input_debouncer.md
DUAL_INPUT_DEBOUNCER -- requirements
Module: dual_input_debouncer

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4, meaning consecutive stable synchronized samples required before an output changes (legal range 2..65535).
REQ-002 SHALL have port i_clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port i_rst_n  input  1  reset; one clock, reset asynchronous and active-low.
REQ-004 SHALL have port i_raw_a  input  1  raw asynchronous level from switch/button A.
REQ-005 SHALL have port i_raw_b  input  1  raw asynchronous level from switch/button B.
REQ-006 SHALL have port o_a  output  1  debounced level A; drives the downstream gate input i_a.
REQ-007 SHALL have port o_b  output  1  debounced level B; drives the downstream gate input i_b.
REQ-008 SHALL have port o_a_rise  output  1  one-cycle pulse on debounced A 0->1.
REQ-009 SHALL have port o_b_rise  output  1  one-cycle pulse on debounced B 0->1.

Function
REQ-010 Each channel SHALL pass its raw input through a 2-flop synchronizer; the second flop output is the sample s.
REQ-011 Each channel SHALL run an independent FSM with states STABLE_LOW, WAIT_HIGH, STABLE_HIGH, WAIT_LOW and a counter cnt of width $clog2(DEBOUNCE_CYCLES).
REQ-012 STABLE_LOW: s=1 -> WAIT_HIGH, cnt=1; else stay, cnt=0.
REQ-013 WAIT_HIGH: s=0 -> STABLE_LOW, cnt=0; s=1 and cnt=DEBOUNCE_CYCLES-1 -> STABLE_HIGH, cnt=0; else cnt+1.
REQ-014 STABLE_HIGH / WAIT_LOW SHALL mirror REQ-012/013 with polarities inverted.
REQ-015 Debounced output SHALL be a registered flop, 1 in STABLE_HIGH and WAIT_LOW, 0 otherwise; it updates on the same edge as the state transition.
REQ-016 Latency: raw level first sampled at edge 1 and held SHALL produce output change at edge DEBOUNCE_CYCLES+2 (6 edges at default).
REQ-017 Any raw pulse or gap shorter than DEBOUNCE_CYCLES synchronized samples SHALL produce no output change and no pulse.
REQ-018 o_x_rise SHALL be high for exactly one cycle, coincident with the cycle o_x first reads 1; no pulse on 1->0.
REQ-019 Channels SHALL be fully independent; simultaneous transitions on A and B SHALL each complete with identical latency.
REQ-020 Counter SHALL never wrap; it saturates logically by the transition in REQ-013.

Reset
REQ-021 i_rst_n low SHALL asynchronously force both synchronizer flops to 0, FSM to STABLE_LOW, cnt to 0, o_a=o_b=0, o_a_rise=o_b_rise=0.
REQ-022 Reset asserted mid-debounce SHALL discard partial counts; after release, a held-high raw input SHALL require the full DEBOUNCE_CYCLES+2 edges again.
REQ-023 Deassertion SHALL be synchronized externally; block SHALL take no action until first clock after release.

Structure
REQ-024 State encodings (2-bit STABLE_LOW=0, WAIT_HIGH=1, STABLE_HIGH=2, WAIT_LOW=3) and the default DEBOUNCE_CYCLES SHALL live in a shared package/header.
REQ-025 One sub-module debounce_channel (synchronizer + FSM + counter + rise pulse) SHALL be instantiated twice.

Verification
REQ-026 Reset, raw A 0->1 held, N=4 -> o_a=1 and o_a_rise=1 at edge 6, o_a_rise=0 at edge 7.
REQ-027 Raw A high for 3 cycles then low, N=4 -> o_a, o_a_rise stay 0 throughout.
REQ-028 A and B rise on same cycle, N=4 -> o_a, o_b, both rise pulses assert at edge 6 together.
REQ-029 o_a=1, raw A 1->0 held -> o_a=0 at edge 6, no rise pulse.
REQ-030 Raw A high, i_rst_n low at edge 4 for 1 cycle -> all outputs 0 immediately; o_a=1 at 6 edges after release.
REQ-031 N=2 bouncing raw A (toggle every cycle 10 cycles, then high) -> single o_a_rise, 4 edges after final high sampled.
